// File: rtl/booth_mult_pkg.sv
// Shared definitions for the radix-2 Booth multiplier.
package booth_mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_mult_step.sv
// One radix-2 Booth step: conditional add/sub of M into the upper
// accumulator, followed by an arithmetic shift right of the whole P register.
module booth_mult_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH+1:0] p_in,
  input  logic [WIDTH:0]     m,
  output logic [2*WIDTH+1:0] p_out
);

  logic [WIDTH:0] upper;
  logic [WIDTH:0] acc;

  // Booth recoding on {q0, q-1}, then ASR by one.
  always_comb begin
    upper = p_in[2*WIDTH+1:WIDTH+1];
    case (p_in[1:0])
      2'b01:   acc = upper + m;
      2'b10:   acc = upper - m;
      default: acc = upper;
    endcase
    p_out = {acc[WIDTH], acc, p_in[WIDTH:1]};
  end

endmodule

// File: rtl/booth_mult.sv
// Sequential signed WIDTHxWIDTH multiplier, one Booth step per clock,
// with a start/finished handshake.
module booth_mult
  import booth_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             finished
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t              state;
  state_t              next_state;
  logic [WIDTH:0]      m;
  logic [2*WIDTH+1:0]  p;
  logic [2*WIDTH+1:0]  p_step;
  logic [CW-1:0]       cnt;
  logic                last_step;

  assign last_step = (cnt == CW'(1));

  booth_mult_step #(.WIDTH(WIDTH)) u_step (
    .p_in  (p),
    .m     (m),
    .p_out (p_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and status outputs; start is only honoured in IDLE.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    finished   = 1'b0;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_step) next_state = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        finished   = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand capture, Booth iteration and result registers.
  // hi/lo are loaded from the final step's output on the edge entering DONE,
  // so the result is visible in the same cycle finished is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      m   <= '0;
      p   <= '0;
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m   <= {a[WIDTH-1], a};
            p   <= {{(WIDTH+1){1'b0}}, b, 1'b0};
            cnt <= CW'(WIDTH);
          end
        end
        ST_RUN: begin
          p   <= p_step;
          cnt <= cnt - CW'(1);
          if (last_step) {hi, lo} <= p_step[2*WIDTH:1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// Directed and random checks of booth_mult against hand-computed products.
module tb_booth_mult;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          finished;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_mult #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .finished (finished)
  );

  // Background monitor: finished is one cycle wide, hi/lo hold between
  // completions and are cleared by reset.
  logic          rst_q = 1'b0;
  logic          fin_prev = 1'b0;
  logic [W-1:0]  held_hi = '0;
  logic [W-1:0]  held_lo = '0;
  bit            mon_on = 1'b0;

  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if (rst_q) begin
        if (hi !== '0 || lo !== '0 || finished !== 1'b0) begin
          errors++;
          $display("FAIL mon_reset_clear: hi=%h lo=%h fin=%b expected 0/0/0", hi, lo, finished);
        end
        held_hi = '0;
        held_lo = '0;
      end else if (finished === 1'b1) begin
        if (fin_prev === 1'b1) begin
          errors++;
          $display("FAIL mon_finished_width: finished high two cycles running, expected one");
        end
        held_hi = hi;
        held_lo = lo;
      end else if (hi !== held_hi || lo !== held_lo) begin
        errors++;
        $display("FAIL mon_hold: hi=%h lo=%h expected held %h %h", hi, lo, held_hi, held_lo);
        held_hi = hi;
        held_lo = lo;
      end
      fin_prev = finished;
    end
  end

  // Issue one multiply from IDLE and wait (bounded) for finished.
  // ncyc counts clocks with the start-sampling edge as clock 1.
  task automatic do_mult(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         output logic [W-1:0] ohi, output logic [W-1:0] olo,
                         output int ncyc);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ncyc = 1;
    while (finished !== 1'b1 && ncyc < 60) begin
      @(posedge clk); #1;
      ncyc++;
    end
    ohi = hi;
    olo = lo;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || finished !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b fin=%b expected 0/0/0/0", hi, lo, busy, finished);
    end
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b expected 0", busy);
    end
    mon_on = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] rh, rl;
    int n;
    do_mult(32'd3, 32'd5, rh, rl, n);
    checks++;
    if (n !== 33) begin
      errors++;
      $display("FAIL basic_latency: got %0d clocks expected 33", n);
    end
    checks++;
    if (rh !== 32'h0000_0000 || rl !== 32'h0000_000F) begin
      errors++;
      $display("FAIL basic_3x5: got %h_%h expected 00000000_0000000f", rh, rl);
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] rh, rl;
    int n;
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, n);
    checks++;
    if (rh !== 32'h0000_0000 || rl !== 32'h0000_0001) begin
      errors++;
      $display("FAIL signed_m1xm1: got %h_%h expected 00000000_00000001", rh, rl);
    end
    do_mult(32'h7FFF_FFFF, 32'hFFFF_FFFF, rh, rl, n);
    checks++;
    if (rh !== 32'hFFFF_FFFF || rl !== 32'h8000_0001) begin
      errors++;
      $display("FAIL signed_maxxm1: got %h_%h expected ffffffff_80000001", rh, rl);
    end
    do_mult(32'h8000_0000, 32'h7FFF_FFFF, rh, rl, n);
    checks++;
    if (rh !== 32'hC000_0000 || rl !== 32'h8000_0000) begin
      errors++;
      $display("FAIL signed_minxmax: got %h_%h expected c0000000_80000000", rh, rl);
    end
    do_mult(32'd0, 32'hDEAD_BEEF, rh, rl, n);
    checks++;
    if (rh !== 32'h0 || rl !== 32'h0) begin
      errors++;
      $display("FAIL signed_zero: got %h_%h expected 00000000_00000000", rh, rl);
    end
  endtask

  task automatic test_corner();
    logic [W-1:0] rh, rl;
    int n;
    do_mult(32'h8000_0000, 32'h8000_0000, rh, rl, n);
    checks++;
    if (rh !== 32'h4000_0000 || rl !== 32'h0000_0000) begin
      errors++;
      $display("FAIL corner_minxmin: got %h_%h expected 40000000_00000000", rh, rl);
    end
  endtask

  task automatic test_back_to_back();
    int fin_count = 0;
    int busy_drop = 0;
    logic [W-1:0] rh = '0;
    logic [W-1:0] rl = '0;
    int n;
    // 100 * 200 = 20000; second start at edge k+5 (7*9) must be dropped,
    // and a/b changing mid-run must not disturb the result.
    a = 32'd100;
    b = 32'd200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      if (i <= 33 && busy !== 1'b1) busy_drop++;
      if (finished === 1'b1) begin
        fin_count++;
        rh = hi;
        rl = lo;
      end
      if (i == 5) begin
        a = 32'd7;
        b = 32'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (i == 12) begin
        a = 32'hFFFF_0000;
        b = 32'h0000_FFFF;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (fin_count !== 1) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d finished pulses expected 1", fin_count);
    end
    checks++;
    if (rh !== 32'h0 || rl !== 32'h0000_4E20) begin
      errors++;
      $display("FAIL b2b_product: got %h_%h expected 00000000_00004e20", rh, rl);
    end
    checks++;
    if (busy_drop !== 0) begin
      errors++;
      $display("FAIL b2b_busy: busy low %0d cycles during run expected 0", busy_drop);
    end

    // start presented only during the DONE cycle is ignored.
    a = 32'd2;
    b = 32'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (finished !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 33) begin
      errors++;
      $display("FAIL done_latency: got %0d clocks expected 33", n);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL done_start_ignored: busy=%b expected 0", busy);
    end
    fin_count = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (finished === 1'b1) fin_count++;
    end
    checks++;
    if (fin_count !== 0 || lo !== 32'd4) begin
      errors++;
      $display("FAIL done_no_rerun: pulses=%0d lo=%h expected 0 pulses lo=00000004", fin_count, lo);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] rh, rl;
    int n;
    int fin_count = 0;
    a = 32'h0001_2345;
    b = 32'h0000_6789;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0 || finished !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b hi=%h lo=%h fin=%b expected 0/0/0/0", busy, hi, lo, finished);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (finished === 1'b1) fin_count++;
    end
    checks++;
    if (fin_count !== 0) begin
      errors++;
      $display("FAIL abort_no_pulse: got %0d pulses expected 0", fin_count);
    end
    do_mult(32'hFFFF_FFF9, 32'd6, rh, rl, n);
    checks++;
    if (rh !== 32'hFFFF_FFFF || rl !== 32'hFFFF_FFD6) begin
      errors++;
      $display("FAIL abort_then_m7x6: got %h_%h expected ffffffff_ffffffd6", rh, rl);
    end
    // Simultaneous reset and start: reset wins.
    a = 32'd3;
    b = 32'd3;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL reset_beats_start: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, rh, rl;
    longint pa, pb;
    logic [2*W-1:0] expv;
    int n;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 16 == 0) ra = 32'h8000_0000;
      if (i % 16 == 1) rb = 32'h8000_0000;
      if (i % 16 == 2) ra = 32'($urandom_range(0, 15)) - 32'd8;
      pa = longint'($signed(ra));
      pb = longint'($signed(rb));
      expv = 64'(pa * pb);
      do_mult(ra, rb, rh, rl, n);
      checks++;
      if ({rh, rl} !== expv) begin
        errors++;
        $display("FAIL random_product: a=%h b=%h got %h_%h expected %h", ra, rb, rh, rl, expv);
      end
      checks++;
      if (n !== 33) begin
        errors++;
        $display("FAIL random_latency: a=%h b=%h got %0d clocks expected 33", ra, rb, n);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_basic();
    test_signed();
    test_corner();
    test_back_to_back();
    test_abort();
    test_random();
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
